lux_roof_decider: RTL

Downstream consumer of the BH1750 sensor front end. It takes paired 16-bit raw light readings, averages them over a 4-sample moving window, and applies threshold hysteresis with consecutive-sample confirmation. It then issues open/close requests to the roof motor controller over a req/ack handshake. It holds the authoritative roof position flag and flags motor-side non-response.

---
 rtl/lux_roof_if.sv | 32 +++
 rtl/lux_roof_decider.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/lux_roof_if.sv
// Sample/command bundle between the light front end, the roof decider and the motor controller.
// Latency: none (wires only).
// Backpressure: the request side holds cmd_req/roof_cmd until cmd_ack; samples are never stalled.
// Ports:
//   lux_a/lux_b/sample_valid   paired raw readings with a one-cycle strobe
//   cmd_ack                    motor controller accepts the pending request
//   lux_avg/avg_ready          filtered light level and window-full flag
//   cmd_req/roof_cmd           pending request and its direction (01 open, 10 close)
//   roof_open/fault            authoritative roof position and last-request-timed-out flag
// The master modport is the decider; the slave modport is its environment.
interface lux_roof_if;
  logic [15:0] lux_a;
  logic [15:0] lux_b;
  logic        sample_valid;
  logic        cmd_ack;
  logic [15:0] lux_avg;
  logic        avg_ready;
  logic        cmd_req;
  logic [1:0]  roof_cmd;
  logic        roof_open;
  logic        fault;

  modport master (
    input  lux_a, lux_b, sample_valid, cmd_ack,
    output lux_avg, avg_ready, cmd_req, roof_cmd, roof_open, fault
  );

  modport slave (
    output lux_a, lux_b, sample_valid, cmd_ack,
    input  lux_avg, avg_ready, cmd_req, roof_cmd, roof_open, fault
  );
endinterface

// File: rtl/lux_roof_decider.sv
// Averages paired light readings over 4 samples, confirms bright/dark with hysteresis, requests roof moves.
// Latency: lux_avg one cycle after sample_valid; cmd_req one cycle after the confirming average.
// Backpressure: a request is held until cmd_ack or ACK_TIMEOUT cycles, then dropped with fault set.
// Ports: clk, rst_n (async active-low), bus (lux_roof_if.master: samples in, ack in, average/request/status out).
module lux_roof_decider #(
  parameter logic [15:0] TH_HIGH     = 16'd1200,
  parameter logic [15:0] TH_LOW      = 16'd300,
  parameter int unsigned CONFIRM     = 3,
  parameter int unsigned ACK_TIMEOUT = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  lux_roof_if.master bus
);

  localparam int unsigned     TW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]      CONF  = 4'(CONFIRM);

  typedef enum logic [1:0] {WARMUP, MONITOR, REQ} state_e;

  // ---------------- averaging window ----------------
  logic [3:0][15:0] win_q;
  logic [17:0]      sum_q;
  logic [17:0]      sum_nxt;
  logic [15:0]      pair_s;
  logic [2:0]       fill_q;
  logic [15:0]      lux_avg_q;
  logic             avg_ready_q;
  logic             avg_upd_q;
  state_e           state_q, state_d;

  // 17-bit pair sum halved back to 16 bits; cannot overflow.
  assign pair_s  = 16'((17'(bus.lux_a) + 17'(bus.lux_b)) >> 1);
  // Empty slots hold zero, so the running sum is exact during fill as well.
  assign sum_nxt = sum_q + {2'b00, pair_s} - {2'b00, win_q[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      lux_avg_q   <= '0;
      avg_ready_q <= 1'b0;
      avg_upd_q   <= 1'b0;
    end else begin
      // A sample landing while a request is open (including the ack cycle) never
      // reaches the confirm counter, so its update strobe is suppressed here.
      avg_upd_q <= bus.sample_valid && (state_q != REQ);
      if (bus.sample_valid) begin
        win_q     <= {win_q[2:0], pair_s};
        sum_q     <= sum_nxt;
        lux_avg_q <= sum_nxt[17:2];
        if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
        avg_ready_q <= avg_ready_q | (fill_q == 3'd3);
      end
    end
  end

  // ---------------- decision FSM ----------------
  logic [3:0]    cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          req_q, req_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          open_q, open_d;
  logic          fault_q, fault_d;
  logic          qualify;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WARMUP;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      cmd_q   <= 2'b00;
      open_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      open_q  <= open_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    open_d  = open_q;
    fault_d = fault_q;
    // Between the thresholds nothing qualifies, whichever way the roof stands.
    qualify = (!open_q && (lux_avg_q >= TH_HIGH)) || (open_q && (lux_avg_q <= TH_LOW));
    cnt_inc = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;

    case (state_q)
      WARMUP: begin
        if (avg_ready_q) state_d = MONITOR;
      end
      MONITOR: begin
        if (avg_upd_q) begin
          if (qualify) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CONF) begin
              state_d = REQ;
              req_d   = 1'b1;
              cmd_d   = open_q ? 2'b10 : 2'b01;
              tcnt_d  = '0;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      REQ: begin
        // Ack wins over a timeout expiring on the same edge.
        if (bus.cmd_ack) begin
          open_d  = !open_q;
          fault_d = 1'b0;
          cnt_d   = '0;
          req_d   = 1'b0;
          cmd_d   = 2'b00;
          state_d = MONITOR;
        end else if (tcnt_q == TLAST) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          req_d   = 1'b0;
          cmd_d   = 2'b00;
          state_d = MONITOR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  assign bus.lux_avg   = lux_avg_q;
  assign bus.avg_ready = avg_ready_q;
  assign bus.cmd_req   = req_q;
  assign bus.roof_cmd  = cmd_q;
  assign bus.roof_open = open_q;
  assign bus.fault     = fault_q;

endmodule
